// File: rtl/tow_referee.sv
// Tug-of-war referee: debounces a push, scores one rope step per round, and locks in a winner.
// Optional build macro TOW_TIE_CNT_EN adds a saturating 4-bit tie_count output.
module tow_referee #(
  parameter int SETTLE_CYC  = 4,
  parameter int HOLDOFF_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       tie,
  input  logic       right,
  output logic       clr,
  output logic [6:0] leds,
  output logic       win_left,
  output logic       win_right,
  output logic       busy,
`ifdef TOW_TIE_CNT_EN
  output logic [3:0] tie_count,
`endif
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_SCORE   = 3'd2,
    S_HOLDOFF = 3'd3,
    S_WIN     = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYC - 1);
  localparam logic [6:0] LEDS_CENTRE  = 7'b0001000;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [6:0] r_leds, w_leds_nxt;
  logic       r_clr, w_clr_nxt;
  logic       r_win_l, w_win_l_nxt;
  logic       r_win_r, w_win_r_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_edge_win;
`ifdef TOW_TIE_CNT_EN
  logic [3:0] r_tie_cnt, w_tie_cnt_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_leds  <= LEDS_CENTRE;
      r_clr   <= 1'b0;
      r_win_l <= 1'b0;
      r_win_r <= 1'b0;
      r_busy  <= 1'b0;
`ifdef TOW_TIE_CNT_EN
      r_tie_cnt <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_leds  <= w_leds_nxt;
      r_clr   <= w_clr_nxt;
      r_win_l <= w_win_l_nxt;
      r_win_r <= w_win_r_nxt;
      r_busy  <= w_busy_nxt;
`ifdef TOW_TIE_CNT_EN
      r_tie_cnt <= w_tie_cnt_nxt;
`endif
    end
  end

  // A non-tie move that would push the rope off either end ends the game instead.
  assign w_edge_win = !tie && ((right && r_leds[6]) || (!right && r_leds[0]));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (push) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!push) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = S_SCORE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_SCORE: begin
        if (w_edge_win) begin
          w_state_nxt = S_WIN;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = HOLDOFF_LOAD;
        end
      end
      S_HOLDOFF: begin
        if (push) begin
          w_cnt_nxt = HOLDOFF_LOAD;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_WIN: begin
        w_state_nxt = S_WIN;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_leds_nxt  = r_leds;
    w_clr_nxt   = 1'b0;
    w_win_l_nxt = r_win_l;
    w_win_r_nxt = r_win_r;
`ifdef TOW_TIE_CNT_EN
    w_tie_cnt_nxt = r_tie_cnt;
`endif
    unique case (r_state)
      S_SCORE: begin
        w_clr_nxt = 1'b1;
        if (tie) begin
`ifdef TOW_TIE_CNT_EN
          if (r_tie_cnt != 4'd15) w_tie_cnt_nxt = r_tie_cnt + 4'd1;
`endif
        end else if (right) begin
          if (r_leds[6]) w_win_r_nxt = 1'b1;
          else           w_leds_nxt  = {r_leds[5:0], 1'b0};
        end else begin
          if (r_leds[0]) w_win_l_nxt = 1'b1;
          else           w_leds_nxt  = {1'b0, r_leds[6:1]};
        end
      end
      S_WIN:   w_clr_nxt = 1'b1;
      default: w_clr_nxt = 1'b0;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign clr       = r_clr;
  assign leds      = r_leds;
  assign win_left  = r_win_l;
  assign win_right = r_win_r;
  assign busy      = r_busy;
  assign dbg_state = r_state;
`ifdef TOW_TIE_CNT_EN
  assign tie_count = r_tie_cnt;
`endif

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee with default SETTLE_CYC=4 / HOLDOFF_CYC=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tow_referee;

  logic       clk;
  logic       rst;
  logic       push;
  logic       tie;
  logic       right;
  logic       clr;
  logic [6:0] leds;
  logic       win_left;
  logic       win_right;
  logic       busy;
  logic [2:0] dbg_state;
`ifdef TOW_TIE_CNT_EN
  logic [3:0] tie_count;
`endif

  int n_tests;
  int n_fail;

  tow_referee #(.SETTLE_CYC(4), .HOLDOFF_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .tie       (tie),
    .right     (right),
    .clr       (clr),
    .leds      (leds),
    .win_left  (win_left),
    .win_right (win_right),
    .busy      (busy),
`ifdef TOW_TIE_CNT_EN
    .tie_count (tie_count),
`endif
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst   = 1'b0;
    push  = 1'b0;
    tie   = 1'b0;
    right = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One full round: push over edges 0..4, score at edge 5, idle by edge 13.
  task automatic play_round(input logic t, input logic r);
    push  = 1'b1;
    tie   = t;
    right = r;
    repeat (5) @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    repeat (9) @(negedge clk);
    tie   = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (leds !== 7'b0001000 || clr !== 1'b0 || busy !== 1'b0 || win_left !== 1'b0 ||
        win_right !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: leds=%b clr=%b busy=%b wl=%b wr=%b st=%0d, want 0001000 0 0 0 0 0",
               leds, clr, busy, win_left, win_right, dbg_state);
    end
`ifdef TOW_TIE_CNT_EN
    n_tests++;
    if (tie_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_tie_count: got %0d want 0", tie_count);
    end
`endif
  endtask

  task automatic test_right_round();
    logic [6:0] exp_leds;
    logic       exp_clr;
    logic       exp_busy;
    do_reset();
    push  = 1'b1;
    right = 1'b1;
    tie   = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      exp_leds = (k >= 5) ? 7'b0010000 : 7'b0001000;
      exp_clr  = (k == 5);
      exp_busy = (k < 13);
      n_tests++;
      if (leds !== exp_leds || clr !== exp_clr || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL right_round cyc%0d: leds=%b clr=%b busy=%b want %b %b %b",
                 k, leds, clr, busy, exp_leds, exp_clr, exp_busy);
      end
      if (k == 4) push = 1'b0;
      if (k == 5) right = 1'b0;
    end
  endtask

  task automatic test_left_walk();
    logic [6:0] exp_leds;
    do_reset();
    exp_leds = 7'b0001000;
    for (int rnd = 1; rnd <= 3; rnd++) begin
      play_round(1'b0, 1'b0);
      exp_leds = {1'b0, exp_leds[6:1]};
      n_tests++;
      if (leds !== exp_leds || win_left !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL left_walk r%0d: leds=%b wl=%b busy=%b want %b 0 0",
                 rnd, leds, win_left, busy, exp_leds);
      end
    end
    for (int rnd = 4; rnd <= 7; rnd++) begin
      play_round(1'b0, (rnd == 6));
      n_tests++;
      if (leds !== 7'b0000001 || win_left !== 1'b1 || win_right !== 1'b0 ||
          clr !== 1'b1 || busy !== 1'b1 || dbg_state !== 3'd4) begin
        n_fail++;
        $display("FAIL left_win r%0d: leds=%b wl=%b wr=%b clr=%b busy=%b st=%0d want 0000001 1 0 1 1 4",
                 rnd, leds, win_left, win_right, clr, busy, dbg_state);
      end
    end
  endtask

  task automatic test_right_win();
    do_reset();
    repeat (3) play_round(1'b0, 1'b1);
    n_tests++;
    if (leds !== 7'b1000000 || win_right !== 1'b0) begin
      n_fail++;
      $display("FAIL right_edge: leds=%b wr=%b want 1000000 0", leds, win_right);
    end
    play_round(1'b0, 1'b1);
    n_tests++;
    if (leds !== 7'b1000000 || win_right !== 1'b1 || win_left !== 1'b0 || clr !== 1'b1) begin
      n_fail++;
      $display("FAIL right_win: leds=%b wr=%b wl=%b clr=%b want 1000000 1 0 1",
               leds, win_right, win_left, clr);
    end
  endtask

  task automatic test_tie();
    do_reset();
    push  = 1'b1;
    tie   = 1'b1;
    right = 1'b1;
    repeat (5) @(negedge clk);
    push = 1'b0;
    n_tests++;
    if (clr !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_pre_clr: got %b want 0", clr);
    end
    @(negedge clk);
    n_tests++;
    if (clr !== 1'b1 || leds !== 7'b0001000) begin
      n_fail++;
      $display("FAIL tie_score: clr=%b leds=%b want 1 0001000", clr, leds);
    end
`ifdef TOW_TIE_CNT_EN
    n_tests++;
    if (tie_count !== 4'd1) begin
      n_fail++;
      $display("FAIL tie_count: got %0d want 1", tie_count);
    end
`endif
    @(negedge clk);
    n_tests++;
    if (clr !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_clr_end: got %b want 0", clr);
    end
    tie   = 1'b0;
    right = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || leds !== 7'b0001000) begin
      n_fail++;
      $display("FAIL tie_idle: busy=%b leds=%b want 0 0001000", busy, leds);
    end
  endtask

  task automatic test_abort();
    do_reset();
    push  = 1'b1;
    right = 1'b1;
    repeat (2) @(negedge clk);
    push = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (clr !== 1'b0 || leds !== 7'b0001000 || busy !== 1'b0 || dbg_state !== 3'd0) begin
        n_fail++;
        $display("FAIL abort cyc%0d: clr=%b leds=%b busy=%b st=%0d want 0 0001000 0 0",
                 k, clr, leds, busy, dbg_state);
      end
    end
    right = 1'b0;
  endtask

  task automatic test_holdoff_reload();
    do_reset();
    push  = 1'b1;
    right = 1'b1;
    repeat (5) @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    right = 1'b0;
    repeat (4) @(negedge clk);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || dbg_state !== 3'd3) begin
      n_fail++;
      $display("FAIL holdoff_reload_busy: busy=%b st=%0d want 1 3", busy, dbg_state);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 3'd0 || leds !== 7'b0010000) begin
      n_fail++;
      $display("FAIL holdoff_reload_idle: busy=%b st=%0d leds=%b want 0 0 0010000",
               busy, dbg_state, leds);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    play_round(1'b0, 1'b1);
    push  = 1'b1;
    right = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 3'd0 || leds !== 7'b0001000 || clr !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_settle: busy=%b st=%0d leds=%b clr=%b want 0 0 0001000 0",
               busy, dbg_state, leds, clr);
    end
    push  = 1'b0;
    right = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    repeat (4) play_round(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (clr !== 1'b0 || win_left !== 1'b0 || leds !== 7'b0001000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_win: clr=%b wl=%b leds=%b busy=%b want 0 0 0001000 0",
               clr, win_left, leds, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    play_round(1'b0, 1'b1);
    n_tests++;
    if (leds !== 7'b0010000 || win_left !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_round: leds=%b wl=%b busy=%b want 0010000 0 0",
               leds, win_left, busy);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_right_round();
    test_left_walk();
    test_right_win();
    test_tie();
    test_abort();
    test_holdoff_reload();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tow_referee.md
TOW_REFEREE -- requirements
Module: tow_referee

Interface
REQ-001 Parameter SETTLE_CYC, default 4, cycles from first push to the tie/right sample; legal range 1..255.
REQ-002 Parameter HOLDOFF_CYC, default 8, consecutive push-low cycles required before the next round is accepted; legal range 1..255.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  any player latched (from push-button latch stage).
REQ-006 tie  input  1  both players latched.
REQ-007 right  input  1  right player latched.
REQ-008 clr  output  1  clear pulse back to the push-button latch stage.
REQ-009 leds  output  7  one-hot rope position; bit 3 is centre, higher index is toward the right player.
REQ-010 win_left  output  1  left player has won.
REQ-011 win_right  output  1  right player has won.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SCORE, HOLDOFF and WIN; all outputs SHALL be registered.
REQ-014 IDLE: push=1 SHALL move the FSM to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-015 SETTLE: the counter SHALL decrement each cycle; at 0 the FSM SHALL go to SCORE; push=0 at any SETTLE cycle SHALL return the FSM to IDLE with no score and no clr.
REQ-016 SCORE (one cycle): tie=1 SHALL leave leds unchanged; tie=0, right=1 SHALL shift leds one place up; tie=0, right=0 SHALL shift leds one place down.
REQ-017 SCORE SHALL assert clr for exactly that one cycle, then go to HOLDOFF, except as stated in REQ-018.
REQ-018 A right move at leds[6] SHALL set win_right=1; a left move at leds[0] SHALL set win_left=1; in both cases leds SHALL hold its value and the FSM SHALL go to WIN.
REQ-019 HOLDOFF: the counter SHALL load HOLDOFF_CYC-1 on entry and decrement while push=0; push=1 SHALL reload the counter; at 0 with push=0 the FSM SHALL go to IDLE.
REQ-020 WIN: clr SHALL be held at 1, push/tie/right SHALL be ignored, and the FSM SHALL leave WIN only on reset.
REQ-021 Latency: the leds update SHALL become visible SETTLE_CYC+1 cycles after the cycle push is first sampled high.
REQ-022 win_left and win_right SHALL never both be 1; leds SHALL always be exactly one-hot.

Reset
REQ-023 rst=0 SHALL immediately force: state IDLE, leds=7'b0001000, clr=0, win_left=0, win_right=0, busy=0, all counters 0 (and tie_count=0 when present).
REQ-024 Reset asserted mid-round, including in WIN, SHALL abandon the round with no clr pulse; release SHALL be treated as a clean IDLE start.

Configuration
REQ-025 Macro TOW_TIE_CNT_EN SHALL control the tie counter.
REQ-026 With TOW_TIE_CNT_EN defined, output tie_count (4 bits) SHALL exist and SHALL increment on each SCORE with tie=1, saturating at 15.
REQ-027 Without TOW_TIE_CNT_EN, the tie_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then push=1, right=1, tie=0 held 5 cycles -> leds 0001000->0010000 on cycle 5, one-cycle clr pulse, busy=1 until 8 push-low cycles have elapsed.
REQ-029 Seven left-only rounds from reset -> leds walks down to 0000001; the fourth round gives win_left=1, leds=0000001, clr stuck at 1, and further pushes are ignored.
REQ-030 push=1 with tie=1 at the sample cycle -> leds unchanged, clr pulses once, and tie_count 0->1 when TOW_TIE_CNT_EN is defined.
REQ-031 push=1 for 2 cycles, then 0 (SETTLE_CYC=4) -> return to IDLE, no clr, leds unchanged.
REQ-032 In HOLDOFF, push is re-asserted on holdoff cycle 5 -> counter reloads, and IDLE is reached only after 8 further push-low cycles.
REQ-033 rst=0 during SETTLE and during WIN -> outputs reach their reset values with no clock edge required.
